// File: rtl/pooled_frame_upsampler.sv
// Streams a pooled frame out one pixel per cycle, nearest-neighbour upsampled by `scale` in both axes.
// Optional macro UPSAMPLER_OVERLAP_EN: accept the next frame on the last-pixel handshake for bubble-free streaming.
module pooled_frame_upsampler #(
    parameter int resolution = 8,
    parameter int in_side    = 2,
    parameter int scale      = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [resolution*in_side*in_side-1:0] frame_in,
    input  logic                                  frame_valid,
    output logic                                  frame_ready,
    output logic [resolution-1:0]                 pix_out,
    output logic                                  pix_valid,
    input  logic                                  pix_ready,
    output logic                                  pix_sol,
    output logic                                  pix_last
);

    localparam int out_side = in_side * scale;
    localparam int num_pix  = in_side * in_side;
    localparam int cnt_w    = (out_side > 1) ? $clog2(out_side) : 1;
    localparam int sub_w    = (scale > 1) ? $clog2(scale) : 1;
    localparam int src_w    = (in_side > 1) ? $clog2(in_side) : 1;
    localparam int idx_w    = (num_pix > 1) ? $clog2(num_pix) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(out_side - 1);
    localparam logic [sub_w-1:0] sub_max = sub_w'(scale - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                        state, state_next;
    logic [resolution*num_pix-1:0] frame_reg;
    logic [cnt_w-1:0]              row, col;
    logic [sub_w-1:0]              sub_row, sub_col;
    logic [src_w-1:0]              src_row, src_col;
    logic [resolution-1:0]         pixels [num_pix];
    logic [idx_w-1:0]              pix_idx;
    logic                          fire, accept, end_of_row, end_of_frame;

    for (genvar i = 0; i < num_pix; i++) begin : g_unpack
        assign pixels[i] = frame_reg[resolution*i +: resolution];
    end

    // src_row/src_col track row/scale and col/scale via the sub-counters, so no divider is needed.
    assign pix_idx      = idx_w'(src_row) * idx_w'(in_side) + idx_w'(src_col);
    assign pix_valid    = (state == STREAM);
    assign pix_out      = pix_valid ? pixels[pix_idx] : '0;
    assign end_of_row   = (col == cnt_max);
    assign end_of_frame = end_of_row && (row == cnt_max);
    assign pix_sol      = pix_valid && (col == '0);
    assign pix_last     = pix_valid && end_of_frame;
    assign fire         = pix_valid && pix_ready;

`ifdef UPSAMPLER_OVERLAP_EN
    assign frame_ready = (state == IDLE) || (pix_last && pix_ready);
`else
    assign frame_ready = (state == IDLE);
`endif

    assign accept = frame_valid && frame_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = STREAM;
            STREAM:  if (fire && end_of_frame && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An accept always lands on a frame boundary, so it restarts every counter at the origin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_reg <= '0;
            row       <= '0;
            col       <= '0;
            sub_row   <= '0;
            sub_col   <= '0;
            src_row   <= '0;
            src_col   <= '0;
        end else if (accept) begin
            frame_reg <= frame_in;
            row       <= '0;
            col       <= '0;
            sub_row   <= '0;
            sub_col   <= '0;
            src_row   <= '0;
            src_col   <= '0;
        end else if (fire) begin
            if (end_of_frame) begin
                row     <= '0;
                col     <= '0;
                sub_row <= '0;
                sub_col <= '0;
                src_row <= '0;
                src_col <= '0;
            end else if (end_of_row) begin
                col     <= '0;
                sub_col <= '0;
                src_col <= '0;
                row     <= row + cnt_w'(1);
                if (sub_row == sub_max) begin
                    sub_row <= '0;
                    src_row <= src_row + src_w'(1);
                end else begin
                    sub_row <= sub_row + sub_w'(1);
                end
            end else begin
                col <= col + cnt_w'(1);
                if (sub_col == sub_max) begin
                    sub_col <= '0;
                    src_col <= src_col + src_w'(1);
                end else begin
                    sub_col <= sub_col + sub_w'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pooled_frame_upsampler.sv
// Directed bench for pooled_frame_upsampler: vector table for backpressure plus hand-written sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pooled_frame_upsampler;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sol;
    logic        pix_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         ready;
        bit         valid;
        logic [7:0] pix;
        bit         sol;
        bit         last;
    } vec_t;

    vec_t bp_table[$];

    logic [7:0] exp_a [16] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h10, 8'h10, 8'h20, 8'h20,
                               8'h30, 8'h30, 8'h40, 8'h40, 8'h30, 8'h30, 8'h40, 8'h40};
    logic [7:0] exp_b [16] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01, 8'h02, 8'h02,
                               8'h03, 8'h03, 8'h04, 8'h04, 8'h03, 8'h03, 8'h04, 8'h04};
    logic [7:0] exp_c [16] = '{8'h55, 8'h55, 8'h66, 8'h66, 8'h55, 8'h55, 8'h66, 8'h66,
                               8'h77, 8'h77, 8'h88, 8'h88, 8'h77, 8'h77, 8'h88, 8'h88};

    pooled_frame_upsampler dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .pix_out     (pix_out),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sol     (pix_sol),
        .pix_last    (pix_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_pixel(input string tag, input int k, input logic [7:0] exp_pix);
        check_output($sformatf("%s_valid%0d", tag, k), 32'(pix_valid), 32'd1);
        check_output($sformatf("%s_pix%0d", tag, k), 32'(pix_out), 32'(exp_pix));
        check_output($sformatf("%s_sol%0d", tag, k), 32'(pix_sol), 32'((k % 4) == 0));
        check_output($sformatf("%s_last%0d", tag, k), 32'(pix_last), 32'(k == 15));
    endtask

    // Present a frame for one cycle; returns at the falling edge where pixel 0 should be visible.
    task automatic apply_stimulus(input logic [31:0] frame);
        check_output("accept_ready", 32'(frame_ready), 32'd1);
        frame_in    = frame;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    initial begin
        int valid_cycles;
        int bubbles;

        for (int k = 0; k < 16; k++) begin
            vec_t v;
            v.ready = 1'b1;
            v.valid = 1'b1;
            v.pix   = exp_a[k];
            v.sol   = ((k % 4) == 0);
            v.last  = (k == 15);
            if (k == 3 || k == 12) begin
                v.ready = 1'b0;
                for (int s = 0; s < 4; s++) bp_table.push_back(v);
                v.ready = 1'b1;
            end
            bp_table.push_back(v);
        end

        reset       = 1'b0;
        frame_in    = 32'h0;
        frame_valid = 1'b0;
        pix_ready   = 1'b0;

        // Reset and idle behaviour
        repeat (3) @(negedge clk);
        check_output("rst_valid", 32'(pix_valid), 32'd0);
        check_output("rst_pix", 32'(pix_out), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("idle_ready", 32'(frame_ready), 32'd1);
        check_output("idle_valid", 32'(pix_valid), 32'd0);
        check_output("idle_pix", 32'(pix_out), 32'd0);
        check_output("idle_sol", 32'(pix_sol), 32'd0);
        check_output("idle_last", 32'(pix_last), 32'd0);
        repeat (5) @(negedge clk);
        check_output("idle_hold_valid", 32'(pix_valid), 32'd0);
        check_output("idle_hold_ready", 32'(frame_ready), 32'd1);

        // Basic upsample
        pix_ready = 1'b1;
        apply_stimulus(32'h40302010);
        for (int k = 0; k < 16; k++) begin
            check_pixel("basic", k, exp_a[k]);
            check_output($sformatf("basic_fready%0d", k), 32'(frame_ready), 32'd0);
            @(negedge clk);
        end
        check_output("basic_end_valid", 32'(pix_valid), 32'd0);
        check_output("basic_end_ready", 32'(frame_ready), 32'd1);

        // Backpressure from the vector table
        apply_stimulus(32'h40302010);
        valid_cycles = 0;
        foreach (bp_table[i]) begin
            pix_ready = bp_table[i].ready;
            if (pix_valid) valid_cycles++;
            check_output($sformatf("bp_valid%0d", i), 32'(pix_valid), 32'(bp_table[i].valid));
            check_output($sformatf("bp_pix%0d", i), 32'(pix_out), 32'(bp_table[i].pix));
            check_output($sformatf("bp_sol%0d", i), 32'(pix_sol), 32'(bp_table[i].sol));
            check_output($sformatf("bp_last%0d", i), 32'(pix_last), 32'(bp_table[i].last));
            @(negedge clk);
        end
        pix_ready = 1'b1;
        check_output("bp_valid_cycles", 32'(valid_cycles), 32'd24);
        check_output("bp_end_valid", 32'(pix_valid), 32'd0);

        // frame_valid during STREAM must be ignored
        apply_stimulus(32'h40302010);
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                frame_in    = 32'hFFFFFFFF;
                frame_valid = 1'b1;
            end
            if (k == 14) frame_valid = 1'b0;
            check_pixel("ign", k, exp_a[k]);
            if (k < 15) check_output($sformatf("ign_fready%0d", k), 32'(frame_ready), 32'd0);
            @(negedge clk);
        end
        check_output("ign_end_valid", 32'(pix_valid), 32'd0);

        // Mid-frame reset, then a fresh frame
        apply_stimulus(32'h40302010);
        for (int k = 0; k < 7; k++) begin
            check_pixel("mid", k, exp_a[k]);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check_output("midrst_valid", 32'(pix_valid), 32'd0);
        check_output("midrst_last", 32'(pix_last), 32'd0);
        check_output("midrst_sol", 32'(pix_sol), 32'd0);
        check_output("midrst_pix", 32'(pix_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("midrst_idle_valid", 32'(pix_valid), 32'd0);
        apply_stimulus(32'h04030201);
        for (int k = 0; k < 16; k++) begin
            check_pixel("post", k, exp_b[k]);
            @(negedge clk);
        end
        check_output("post_end_valid", 32'(pix_valid), 32'd0);

        // Back-to-back frames with frame_valid held high
        valid_cycles = 0;
        bubbles      = 0;
        frame_in     = 32'h40302010;
        frame_valid  = 1'b1;
        @(negedge clk);
        frame_in = 32'h88776655;
        for (int k = 0; k < 16; k++) begin
            if (pix_valid) valid_cycles++;
            check_pixel("ovA", k, exp_a[k]);
`ifdef UPSAMPLER_OVERLAP_EN
            if (k == 15) check_output("ov_last_fready", 32'(frame_ready), 32'd1);
`else
            if (k == 15) check_output("ov_last_fready", 32'(frame_ready), 32'd0);
`endif
            @(negedge clk);
        end
        if (!pix_valid) begin
            bubbles++;
            check_output("ov_bubble_fready", 32'(frame_ready), 32'd1);
            @(negedge clk);
        end
        frame_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (pix_valid) valid_cycles++;
            check_pixel("ovC", k, exp_c[k]);
            @(negedge clk);
        end
        check_output("ov_valid_cycles", 32'(valid_cycles), 32'd32);
`ifdef UPSAMPLER_OVERLAP_EN
        check_output("ov_bubbles", 32'(bubbles), 32'd0);
`else
        check_output("ov_bubbles", 32'(bubbles), 32'd1);
`endif
        check_output("ov_end_valid", 32'(pix_valid), 32'd0);
        check_output("ov_end_ready", 32'(frame_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
